ad_acq_scheduler: RTL
=====================

Name: ad_acq_scheduler

Overview:
- Sequences AD7606 acquisition frames at a programmable sample rate and counts the 8 channel samples returned per frame.
- Tags each enabled channel sample with its channel index and writes it into the downstream capture FIFO.
- Tracks overruns, FIFO drops and frame timeouts.
- Sits between the host/control registers and the AD7606 front-end controller (conversion request out; sample valid/data in), and feeds the FIFO.

Parameters:
- MIN_DIV, 16'd64, minimum conversion period in clk cycles; smaller cfg_div is clamped to this.
- TIMEOUT_CYC, 16'd1024, max cycles in COLLECT from conv_req to the 8th sample before the frame aborts.
- NUM_CH, 8, samples per frame; fixed at 8 for AD7606.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- start  in  1  1-cycle pulse; latches config and begins acquisition
- stop  in  1  1-cycle pulse; ends acquisition after the current frame
- cfg_div  in  16  conversion period in clk cycles
- cfg_frames  in  16  frames per run; 0 = continuous
- cfg_ch_mask  in  8  bit n=1 writes channel n+1 to the FIFO
- conv_req  out  1  1-cycle pulse requesting one conversion and readout from the front end
- smp_valid  in  1  1-cycle strobe per channel sample, CH1..CH8 in order
- smp_data  in  16  sample value, valid with smp_valid
- fifo_full  in  1  capture FIFO full
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  19  {ch_idx[2:0], sample[15:0]}; ch_idx 0 = CH1
- busy  out  1  high from start until return to IDLE
- done  out  1  1-cycle pulse on return to IDLE
- frame_cnt  out  16  frames completed in the current run
- overrun_cnt  out  8  ticks missed while a frame was in progress; saturating
- drop_cnt  out  8  samples dropped due to fifo_full; saturating
- timeout_err  out  1  sticky; set on frame timeout, cleared by start

Behaviour:
- Reset (rst_n low, async): state IDLE. All outputs 0. Internal counters and latched config 0.
- Config latch on start in IDLE:
  - div_r = max(cfg_div, MIN_DIV); frames_r = cfg_frames; mask_r = cfg_ch_mask.
  - frame_cnt, overrun_cnt, drop_cnt and timeout_err clear.
  - Tick counter loads 0.
- start while busy is ignored. start and stop in the same IDLE cycle: stop wins, no run begins.
- Tick counter: runs while busy. Counts 0..div_r-1, then wraps; a tick is asserted at wrap. First tick fires div_r cycles after start.
- FSM:
  - IDLE: wait for start -> WAIT_TICK.
  - WAIT_TICK:
    - If a stop is pending -> DONE.
    - Else on tick: conv_req=1 for exactly that cycle; sample counter=0; timeout counter=0 -> COLLECT.
  - COLLECT:
    - Each smp_valid increments the sample counter; ch_idx = current sample count.
    - If mask_r[ch_idx]=1: write the sample this cycle if fifo_full=0 (fifo_wr_en=1, registered, 1-cycle latency from smp_valid). If fifo_full=1, no write and drop_cnt++ (saturating at 255).
    - Masked-out channels are counted but never written.
    - On the 8th smp_valid: frame_cnt++ -> CHECK.
    - If the timeout counter reaches TIMEOUT_CYC first: timeout_err=1; frame not counted -> CHECK.
  - CHECK: if stop pending, or (frames_r!=0 and frame_cnt==frames_r) -> DONE; else -> WAIT_TICK.
  - DONE: done=1 for one cycle; busy=0 -> IDLE.
- A tick occurring while in COLLECT or CHECK does not issue conv_req; overrun_cnt++ (saturating at 255).
- stop received anywhere while busy sets stop_pending. The current frame always completes or times out before DONE. stop_pending clears in IDLE.
- smp_valid outside COLLECT is ignored: no write, no count.
- frame_cnt does not wrap in finite mode. In continuous mode it wraps 0xFFFF->0.
- Reset asserted mid-frame aborts immediately; no partial write is completed.

Test Plan:
- cfg_div=100, cfg_frames=3, mask=8'hFF, start; front end returns 8 valids 20 cycles after each conv_req -> conv_req at cycles 100, 200, 300; 24 FIFO writes with ch_idx 0..7 repeating; frame_cnt=3; done pulse once; busy low afterwards.
- cfg_div=10 -> clamped to 64; conv_req spacing exactly 64 cycles.
- mask=8'b1000_0101, 1 frame -> exactly 3 writes, ch_idx 0, 2, 7 with matching data.
- fifo_full held high during samples 3–5 of a frame, mask=FF -> 5 writes; drop_cnt=3.
- Frame readout takes 150 cycles with cfg_div=100 -> overrun_cnt increments by 1 per frame; conv_req only after CHECK.
- Only 5 valids returned for a frame -> timeout_err=1 after 1024 cycles; frame_cnt unchanged; next start clears timeout_err.
- Continuous mode, stop pulsed mid-COLLECT -> frame finishes (8 writes), then done pulse and IDLE; no further conv_req.

Source files
------------

// File: rtl/ad_acq_scheduler.sv
// AD7606 acquisition scheduler: paces conversion requests, tags returned channel
// samples with their index for the capture FIFO, and tracks overruns, drops and timeouts.
module ad_acq_scheduler #(
  parameter logic [15:0] MIN_DIV     = 16'd64,
  parameter logic [15:0] TIMEOUT_CYC = 16'd1024,
  parameter int unsigned NUM_CH      = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] cfg_div,
  input  logic [15:0] cfg_frames,
  input  logic [7:0]  cfg_ch_mask,
  output logic        conv_req,
  input  logic        smp_valid,
  input  logic [15:0] smp_data,
  input  logic        fifo_full,
  output logic        fifo_wr_en,
  output logic [18:0] fifo_wr_data,
  output logic        busy,
  output logic        done,
  output logic [15:0] frame_cnt,
  output logic [7:0]  overrun_cnt,
  output logic [7:0]  drop_cnt,
  output logic        timeout_err
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_TICK, S_COLLECT, S_CHECK, S_DONE} state_e;

  localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

  state_e      state_q, state_d;
  logic [15:0] div_q, div_d, frames_q, frames_d;
  logic [15:0] tick_cnt_q, tick_cnt_d, to_cnt_q, to_cnt_d, frame_cnt_q, frame_cnt_d;
  logic [7:0]  mask_q, mask_d, overrun_q, overrun_d, drop_q, drop_d;
  logic [2:0]  smp_cnt_q, smp_cnt_d;
  logic        stop_pend_q, stop_pend_d, timeout_q, timeout_d;
  logic        conv_req_q, conv_req_d, wr_en_q, wr_en_d;
  logic [18:0] wr_data_q, wr_data_d;
  logic        busy_w, tick_w;

  assign busy_w = (state_q == S_WAIT_TICK) || (state_q == S_COLLECT) || (state_q == S_CHECK);
  assign tick_w = busy_w && (tick_cnt_q == div_q - 16'd1);

  always_comb begin
    // NOTE: every _d gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    div_d       = div_q;
    frames_d    = frames_q;
    mask_d      = mask_q;
    tick_cnt_d  = tick_cnt_q;
    to_cnt_d    = to_cnt_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = overrun_q;
    drop_d      = drop_q;
    smp_cnt_d   = smp_cnt_q;
    stop_pend_d = stop_pend_q;
    timeout_d   = timeout_q;
    wr_data_d   = wr_data_q;
    conv_req_d  = 1'b0;
    wr_en_d     = 1'b0;

    if (busy_w) tick_cnt_d = tick_w ? 16'd0 : tick_cnt_q + 16'd1;
    if (busy_w && stop) stop_pend_d = 1'b1;
    // A tick that lands while a frame is still being read out is lost.
    if (tick_w && (state_q == S_COLLECT || state_q == S_CHECK) && overrun_q != 8'hFF)
      overrun_d = overrun_q + 8'd1;

    unique case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (start && !stop) begin
          div_d       = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;
          frames_d    = cfg_frames;
          mask_d      = cfg_ch_mask;
          frame_cnt_d = 16'd0;
          overrun_d   = 8'd0;
          drop_d      = 8'd0;
          timeout_d   = 1'b0;
          tick_cnt_d  = 16'd0;
          state_d     = S_WAIT_TICK;
        end
      end
      S_WAIT_TICK: begin
        if (stop_pend_q) begin
          state_d = S_DONE;
        end else if (tick_w) begin
          conv_req_d = 1'b1;
          smp_cnt_d  = 3'd0;
          to_cnt_d   = 16'd0;
          state_d    = S_COLLECT;
        end
      end
      S_COLLECT: begin
        to_cnt_d = to_cnt_q + 16'd1;
        if (smp_valid) begin
          smp_cnt_d = smp_cnt_q + 3'd1;
          if (mask_q[smp_cnt_q]) begin
            if (!fifo_full) begin
              wr_en_d   = 1'b1;
              wr_data_d = {smp_cnt_q, smp_data};
            end else if (drop_q != 8'hFF) begin
              drop_d = drop_q + 8'd1;
            end
          end
        end
        // The last sample wins over a timeout expiring in the same cycle.
        if (smp_valid && smp_cnt_q == LAST_CH) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = S_CHECK;
        end else if (to_cnt_q == TIMEOUT_CYC - 16'd1) begin
          timeout_d = 1'b1;
          state_d   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (stop_pend_q || (frames_q != 16'd0 && frame_cnt_q == frames_q)) state_d = S_DONE;
        else state_d = S_WAIT_TICK;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      frames_q    <= '0;
      mask_q      <= '0;
      tick_cnt_q  <= '0;
      to_cnt_q    <= '0;
      frame_cnt_q <= '0;
      overrun_q   <= '0;
      drop_q      <= '0;
      smp_cnt_q   <= '0;
      stop_pend_q <= 1'b0;
      timeout_q   <= 1'b0;
      conv_req_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of its peers.
      state_q     <= state_d;
      div_q       <= div_d;
      frames_q    <= frames_d;
      mask_q      <= mask_d;
      tick_cnt_q  <= tick_cnt_d;
      to_cnt_q    <= to_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
      drop_q      <= drop_d;
      smp_cnt_q   <= smp_cnt_d;
      stop_pend_q <= stop_pend_d;
      timeout_q   <= timeout_d;
      conv_req_q  <= conv_req_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign conv_req     = conv_req_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign busy         = busy_w;
  assign done         = (state_q == S_DONE);
  assign frame_cnt    = frame_cnt_q;
  assign overrun_cnt  = overrun_q;
  assign drop_cnt     = drop_q;
  assign timeout_err  = timeout_q;

endmodule
